syzygy_adc_align_ctrl: RTL and testbench

Frame-alignment controller for the SYZYGY ADC capture path. Runs in the divided (slow) clock domain and watches the 8-bit parallel word from the frame-channel ISERDES. Issues single-cycle bitslip pulses, spaced by a settle interval, until the word matches the expected frame pattern. Declares lock, supervises it, and reports slip count and status to the data-lane ISERDES and the host register interface.

---
 rtl/syzygy_adc_align_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_syzygy_adc_align_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_adc_align_ctrl.sv
// syzygy_adc_align_ctrl
// Frame-alignment controller for the SYZYGY ADC capture path. It watches the
// frame-channel ISERDES word in the slow clock domain, issues spaced bitslip
// pulses until the frame pattern is seen MATCH_COUNT times in a row, then
// supervises lock and reports status.
//
// Ports:
//   slow_clk       in   divided capture clock
//   reset_n        in   asynchronous active-low reset
//   ena            in   alignment enable; low forces IDLE
//   restart        in   one-cycle pulse; restarts alignment, clears sticky flags
//   frame_word     in   frame-channel ISERDES parallel word
//   bitslip        out  one-cycle slip pulse
//   bitslip_count  out  slips applied in this attempt, modulo DATA_WIDTH
//   aligned        out  high while LOCKED
//   data_valid     out  aligned delayed one cycle
//   align_fail     out  sticky: attempt exhausted DATA_WIDTH slips
//   lock_lost      out  sticky: loss of lock detected
//
// Optional feature macro: SYZYGY_ALIGN_AUTO_RELOCK_EN
//   defined   - loss of lock restarts the search from the current slip position
//   undefined - loss of lock only sets lock_lost; LOCKED and aligned are held
module syzygy_adc_align_ctrl #(
    parameter int unsigned               DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0]     FRAME_PATTERN = DATA_WIDTH'(8'hF0),
    parameter int unsigned               SETTLE_CYCLES = 4,
    parameter int unsigned               MATCH_COUNT   = 16,
    parameter int unsigned               LOSS_COUNT    = 4
) (
    input  logic                  slow_clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] frame_word,
    output logic                  bitslip,
    output logic [3:0]            bitslip_count,
    output logic                  aligned,
    output logic                  data_valid,
    output logic                  align_fail,
    output logic                  lock_lost
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SLIP_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned BSC_W    = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    loss_cnt_q, loss_cnt_d;
    logic [SLIP_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic [BSC_W-1:0]    bitslip_count_d;
    logic                bitslip_d;
    logic                aligned_d;
    logic                data_valid_d;
    logic                align_fail_d;
    logic                lock_lost_d;

    logic                frame_match;
    logic                loss_event;

    assign frame_match = (frame_word == FRAME_PATTERN);

    // Final mismatch of a run that declares loss of lock
    assign loss_event = (state_q == LOCKED) && !frame_match &&
                        (loss_cnt_q == CNT_W'(LOSS_COUNT - 1));

    // State and registered outputs
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            match_cnt_q   <= '0;
            loss_cnt_q    <= '0;
            slip_cnt_q    <= '0;
            bitslip       <= 1'b0;
            bitslip_count <= '0;
            aligned       <= 1'b0;
            data_valid    <= 1'b0;
            align_fail    <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            match_cnt_q   <= match_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            slip_cnt_q    <= slip_cnt_d;
            bitslip       <= bitslip_d;
            bitslip_count <= bitslip_count_d;
            aligned       <= aligned_d;
            data_valid    <= data_valid_d;
            align_fail    <= align_fail_d;
            lock_lost     <= lock_lost_d;
        end
    end

    // Next state; restart and ena deassertion override every transition
    always_comb begin
        state_d = state_q;
        if (restart || !ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SETTLE;
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (frame_match) begin
                        if (match_cnt_q == CNT_W'(MATCH_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else if (slip_cnt_q < SLIP_W'(DATA_WIDTH)) begin
                        state_d = SLIP;
                    end else begin
                        state_d = FAIL;
                    end
                end
                SLIP: state_d = SETTLE;
                LOCKED: begin
`ifdef SYZYGY_ALIGN_AUTO_RELOCK_EN
                    if (loss_event) begin
                        state_d = SETTLE;
                    end
`else
                    state_d = LOCKED;
`endif
                end
                FAIL:    state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters and next values of the registered outputs
    always_comb begin
        settle_cnt_d    = '0;
        match_cnt_d     = match_cnt_q;
        loss_cnt_d      = loss_cnt_q;
        slip_cnt_d      = slip_cnt_q;
        bitslip_count_d = bitslip_count;
        bitslip_d       = (state_d == SLIP);
        aligned_d       = (state_d == LOCKED);
        data_valid_d    = aligned;
        align_fail_d    = align_fail;
        lock_lost_d     = lock_lost;

        if ((state_q == SETTLE) && (state_d == SETTLE)) begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end

        case (state_q)
            CHECK: begin
                if (frame_match) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end else begin
                    match_cnt_d = '0;
                end
            end
            SLIP: begin
                // bitslip_count wraps; the attempt slip counter saturates
                if (bitslip_count == BSC_W'(DATA_WIDTH - 1)) begin
                    bitslip_count_d = '0;
                end else begin
                    bitslip_count_d = bitslip_count + BSC_W'(1);
                end
                if (slip_cnt_q != SLIP_W'(DATA_WIDTH)) begin
                    slip_cnt_d = slip_cnt_q + SLIP_W'(1);
                end
            end
            LOCKED: begin
                if (frame_match || loss_event) begin
                    loss_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (loss_event) begin
            lock_lost_d = 1'b1;
`ifdef SYZYGY_ALIGN_AUTO_RELOCK_EN
            // Fresh attempt from the current slip position
            match_cnt_d = '0;
            slip_cnt_d  = '0;
`endif
        end

        if (state_d == FAIL) begin
            align_fail_d = 1'b1;
        end

        if (state_d == IDLE) begin
            settle_cnt_d    = '0;
            match_cnt_d     = '0;
            loss_cnt_d      = '0;
            slip_cnt_d      = '0;
            bitslip_count_d = '0;
        end

        if (restart) begin
            align_fail_d    = 1'b0;
            lock_lost_d     = 1'b0;
            bitslip_count_d = '0;
        end
    end

endmodule

// File: tb/tb_syzygy_adc_align_ctrl.sv
// Testbench for syzygy_adc_align_ctrl: table of alignment scenarios plus
// directed sequences for latency, loss of lock, restart and reset corners.
module tb_syzygy_adc_align_ctrl;

    logic       slow_clk = 1'b0;
    logic       reset_n;
    logic       ena;
    logic       restart;
    logic [7:0] frame_word;
    logic       bitslip;
    logic [3:0] bitslip_count;
    logic       aligned;
    logic       data_valid;
    logic       align_fail;
    logic       lock_lost;

    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   pulses     = 0;
    int   last_pulse = -1;
    logic rot_en     = 1'b0;

    syzygy_adc_align_ctrl dut (
        .slow_clk      (slow_clk),
        .reset_n       (reset_n),
        .ena           (ena),
        .restart       (restart),
        .frame_word    (frame_word),
        .bitslip       (bitslip),
        .bitslip_count (bitslip_count),
        .aligned       (aligned),
        .data_valid    (data_valid),
        .align_fail    (align_fail),
        .lock_lost     (lock_lost)
    );

    always #5 slow_clk = ~slow_clk;

    typedef struct {
        logic [7:0] word;
        logic       rot;
        int         cycles;
        int         exp_pulses;
        int         exp_bsc;
        int         exp_aligned;
        int         exp_fail;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; models the frame ISERDES rotating right by one bit per slip
    task automatic step();
        @(posedge slow_clk);
        #1;
        cyc++;
        if (bitslip) begin
            pulses++;
            if (last_pulse >= 0) begin
                total++;
                if (cyc - last_pulse < 6) begin
                    bad++;
                    $display("FAIL pulse_gap: got %0d cycles expected >= 6", cyc - last_pulse);
                end
            end
            last_pulse = cyc;
            if (rot_en) frame_word = {frame_word[0], frame_word[7:1]};
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ena     = 1'b0;
        restart = 1'b0;
        @(posedge slow_clk);
        #1;
        @(posedge slow_clk);
        #1;
        reset_n    = 1'b1;
        cyc        = 0;
        pulses     = 0;
        last_pulse = -1;
    endtask

    initial begin
        int n;
        int drops;

        vecs[0] = '{8'hF0, 1'b1, 40, 0, 0, 1, 0};
        vecs[1] = '{8'h87, 1'b1, 60, 3, 3, 1, 0};
        vecs[2] = '{8'hE1, 1'b1, 50, 1, 1, 1, 0};
        vecs[3] = '{8'h0F, 1'b1, 80, 4, 4, 1, 0};
        vecs[4] = '{8'h1E, 1'b1, 80, 5, 5, 1, 0};
        vecs[5] = '{8'h78, 1'b1, 80, 7, 7, 1, 0};
        vecs[6] = '{8'hAA, 1'b0, 80, 8, 0, 0, 1};
        vecs[7] = '{8'h00, 1'b0, 80, 8, 0, 0, 1};

        // Reset state
        reset_n    = 1'b0;
        ena        = 1'b0;
        restart    = 1'b0;
        frame_word = 8'h00;
        #12;
        check("rst_bitslip", int'(bitslip), 0);
        check("rst_bsc", int'(bitslip_count), 0);
        check("rst_aligned", int'(aligned), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_align_fail", int'(align_fail), 0);
        check("rst_lock_lost", int'(lock_lost), 0);

        // Table-driven alignment scenarios
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            frame_word = vecs[i].word;
            rot_en     = vecs[i].rot;
            ena        = 1'b1;
            run(vecs[i].cycles);
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            check($sformatf("vec%0d_bsc", i), int'(bitslip_count), vecs[i].exp_bsc);
            check($sformatf("vec%0d_aligned", i), int'(aligned), vecs[i].exp_aligned);
            check($sformatf("vec%0d_data_valid", i), int'(data_valid), vecs[i].exp_aligned);
            check($sformatf("vec%0d_align_fail", i), int'(align_fail), vecs[i].exp_fail);
            check($sformatf("vec%0d_lock_lost", i), int'(lock_lost), 0);
        end

        // Lock latency with an already-aligned input
        apply_reset();
        frame_word = 8'hF0;
        rot_en     = 1'b1;
        ena        = 1'b1;
        n = 0;
        while (!aligned && n < 100) begin
            step();
            n++;
        end
        check("lock_latency", n, 21);
        check("latency_dv_low", int'(data_valid), 0);
        step();
        check("latency_dv_high", int'(data_valid), 1);

        // Loss of lock after four mismatches
        apply_reset();
        frame_word = 8'h87;
        rot_en     = 1'b1;
        ena        = 1'b1;
        run(60);
        check("loss_pre_bsc", int'(bitslip_count), 3);
        check("loss_pre_aligned", int'(aligned), 1);
        frame_word = 8'h0F;
        pulses     = 0;
        run(3);
        check("loss3_lock_lost", int'(lock_lost), 0);
        check("loss3_aligned", int'(aligned), 1);
        step();
        check("loss4_lock_lost", int'(lock_lost), 1);
`ifdef SYZYGY_ALIGN_AUTO_RELOCK_EN
        check("loss4_aligned", int'(aligned), 0);
        check("loss4_bsc_kept", int'(bitslip_count), 3);
        run(80);
        check("relock_aligned", int'(aligned), 1);
        check("relock_bsc", int'(bitslip_count), 7);
        check("relock_pulses", pulses, 4);
        check("relock_lock_lost", int'(lock_lost), 1);
`else
        check("loss4_aligned", int'(aligned), 1);
        run(20);
        check("hold_aligned", int'(aligned), 1);
        check("hold_pulses", pulses, 0);
        check("hold_bsc", int'(bitslip_count), 3);
        check("hold_lock_lost", int'(lock_lost), 1);
`endif
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_lock_lost", int'(lock_lost), 0);
        check("restart_bsc", int'(bitslip_count), 0);
        check("restart_aligned", int'(aligned), 0);

        // 3 mismatches, 1 match, 3 mismatches: no loss
        apply_reset();
        frame_word = 8'hF0;
        rot_en     = 1'b0;
        ena        = 1'b1;
        run(30);
        check("glitch_pre_aligned", int'(aligned), 1);
        drops = 0;
        for (int k = 0; k < 9; k++) begin
            frame_word = (k == 3 || k >= 7) ? 8'hF0 : 8'h0F;
            step();
            if (!aligned) drops++;
        end
        check("glitch_drops", drops, 0);
        check("glitch_lock_lost", int'(lock_lost), 0);

        // Asynchronous reset in the middle of CHECK
        apply_reset();
        frame_word = 8'h87;
        rot_en     = 1'b1;
        ena        = 1'b1;
        run(30);
        check("midchk_bsc", int'(bitslip_count), 3);
        check("midchk_aligned", int'(aligned), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_bsc", int'(bitslip_count), 0);
        check("async_bitslip", int'(bitslip), 0);
        check("async_aligned", int'(aligned), 0);
        reset_n = 1'b1;

        // Restart during FAIL; sticky flag survives ena deassertion
        apply_reset();
        frame_word = 8'hAA;
        rot_en     = 1'b0;
        ena        = 1'b1;
        run(70);
        check("fail_align_fail", int'(align_fail), 1);
        ena = 1'b0;
        step();
        check("fail_ena_low_sticky", int'(align_fail), 1);
        ena        = 1'b1;
        frame_word = 8'hF0;
        restart    = 1'b1;
        step();
        restart = 1'b0;
        check("fail_restart_clear", int'(align_fail), 0);
        check("fail_restart_bsc", int'(bitslip_count), 0);
        pulses = 0;
        run(25);
        check("fail_relock_aligned", int'(aligned), 1);
        check("fail_relock_pulses", pulses, 0);

        // Restart mid-attempt clears a nonzero bitslip_count
        apply_reset();
        frame_word = 8'h87;
        rot_en     = 1'b1;
        ena        = 1'b1;
        run(15);
        check("mid_bsc", int'(bitslip_count), 2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("mid_restart_bsc", int'(bitslip_count), 0);
        run(50);
        check("mid_relock_bsc", int'(bitslip_count), 1);
        check("mid_relock_aligned", int'(aligned), 1);

        // Restart coinciding with the final match: no lock
        apply_reset();
        frame_word = 8'hF0;
        rot_en     = 1'b0;
        ena        = 1'b1;
        run(20);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("race_aligned", int'(aligned), 0);
        run(20);
        check("race_before_relock", int'(aligned), 0);
        step();
        check("race_relock", int'(aligned), 1);

        // ena deassertion from LOCKED
        apply_reset();
        frame_word = 8'hF0;
        ena        = 1'b1;
        run(25);
        check("ena_pre_aligned", int'(aligned), 1);
        ena = 1'b0;
        step();
        check("ena_off_aligned", int'(aligned), 0);
        check("ena_off_dv_delayed", int'(data_valid), 1);
        step();
        check("ena_off_dv", int'(data_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
